// File: rtl/data_ram_ctrl.sv
// Data memory controller: byte-lane writes, req/ready handshake, WAIT_CYCLES wait states per access.
// Optional build macro DATA_RAM_RANGE_CHECK_EN flags out-of-range accesses on err and suppresses them.
module data_ram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [DATA_W/8-1:0] wen,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                busy,
    output logic                err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
    localparam logic [3:0] LAST_CNT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [3:0]        cnt_r, cnt_next_s;
    logic [IDX_W-1:0]  idx_r, addr_idx_s, rd_idx_s;
    logic [LANES-1:0]  wen_r;
    logic [DATA_W-1:0] wdata_r, rdata_r;
    logic              oor_r, addr_oor_s, rd_oor_s;
    logic              ready_r, busy_r, err_r;
    logic              accept_s, enter_resp_s;
    logic              unused_addr_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    assign addr_idx_s    = addr[OFF_W +: IDX_W];
    assign unused_addr_s = ^addr;

`ifdef DATA_RAM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * LANES);
    assign addr_oor_s = ({1'b0, addr} >= MEM_BYTES);
`else
    // Upper address bits are dropped, so the index simply wraps modulo DEPTH.
    assign addr_oor_s = 1'b0;
`endif

    assign accept_s     = (state_r == ST_IDLE) && req;
    assign enter_resp_s = (state_next_s == ST_RESP);

    // Read index: a zero-wait access enters RESP on its accept edge, before idx_r is loaded.
    always_comb begin
        rd_idx_s = idx_r;
        rd_oor_s = oor_r;
        if (state_r == ST_IDLE) begin
            rd_idx_s = addr_idx_s;
            rd_oor_s = addr_oor_s;
        end else begin
            rd_idx_s = idx_r;
            rd_oor_s = oor_r;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    cnt_next_s   = 4'd0;
                    state_next_s = HAS_WAIT ? ST_WAIT : ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_next_s = cnt_r + 4'd1;
                if (cnt_r == LAST_CNT) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State register and access capture at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            wen_r   <= '0;
            wdata_r <= '0;
            oor_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                idx_r   <= addr_idx_s;
                wen_r   <= wen;
                wdata_r <= wdata;
                oor_r   <= addr_oor_s;
            end
        end
    end

    // Registered outputs; rdata samples the pre-write word on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            ready_r <= enter_resp_s;
            busy_r  <= (state_next_s != ST_IDLE);
            err_r   <= enter_resp_s & rd_oor_s;
            if (enter_resp_s) begin
                rdata_r <= rd_oor_s ? '0 : mem_r[rd_idx_s];
            end
        end
    end

    // Storage write on the edge closing RESP; a reset in RESP discards it.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_RESP) && !oor_r) begin
            for (int i = 0; i < LANES; i++) begin
                if (wen_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_r;
    assign ready = ready_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule
